axi_stream_packer: RTL and testbench
====================================

Name: axi_stream_packer

Overview:
- Width upsizer placed directly upstream of the register slice on a streaming valid/ready channel.
- Packs RATIO consecutive narrow input beats into one wide output beat.
- An input beat with s_axi_last set closes the wide word early. That word is emitted zero-padded, with a lane-valid mask.
- Output is fully registered, so the downstream slice sees registered valid/data/keep/last.

Parameters:
- DATA_WIDTH, 32, width of one input beat (bits).
- RATIO, 4, number of input beats per output beat. Legal values 1..16. Output data width is DATA_WIDTH*RATIO.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- s_axi_valid  input  1  input beat valid.
- s_axi_ready  output  1  packer accepts input beat this cycle.
- s_axi_data  input  DATA_WIDTH  input beat payload.
- s_axi_last  input  1  final beat of a packet; closes the current wide word.
- m_axi_valid  output  1  wide word valid.
- m_axi_ready  input  1  downstream accepts wide word.
- m_axi_data  output  DATA_WIDTH*RATIO  packed word; first beat in lane 0 (LSBs).
- m_axi_keep  output  RATIO  bit i set when lane i holds a received beat.
- m_axi_last  output  1  wide word contains a beat that had s_axi_last set.

Behaviour:
- Reset (resetn=0 at a clk edge): m_axi_valid=0, m_axi_data=0, m_axi_keep=0, m_axi_last=0, lane counter=0. s_axi_ready evaluates to 1.
- Reset asserted mid-word discards any partially packed beats. Nothing is emitted for them.
- Storage is a single wide register (data, keep, last) plus a lane counter cnt, 0..RATIO-1, of width max(1,clog2(RATIO)).
- s_axi_ready = ~m_axi_valid | m_axi_ready (combinational; no other dependency on s_axi_valid).
- Input accept = s_axi_valid & s_axi_ready. Output transfer = m_axi_valid & m_axi_ready.
- On input accept, beat is written to lane cnt and keep[cnt] is set.
  - If cnt==RATIO-1 or s_axi_last=1: m_axi_valid<=1 on the next cycle, m_axi_last<=s_axi_last, cnt<=0.
  - Otherwise: cnt<=cnt+1, m_axi_valid stays 0.
- When a word is started in the cycle of an output transfer (cnt==0 and transfer and accept together), lane 0 takes the new beat. All other lanes are zeroed and keep becomes 1 in bit 0 only.
  - If that beat also completes the word (RATIO=1 or last), m_axi_valid stays 1.
  - Otherwise m_axi_valid falls to 0.
- Output transfer with no input accept: m_axi_valid<=0. data, keep and last are cleared to 0 on the next cycle.
- Early close (last with cnt<RATIO-1): unfilled lanes are 0 and their keep bits are 0.
- Latency: wide word is valid one cycle after the accept of its final beat.
- Throughput: one input beat per cycle sustained while m_axi_ready=1. No bubble between consecutive wide words.
- While m_axi_valid=1 and m_axi_ready=0: s_axi_ready=0, and m_axi_data/keep/last are held stable.
- While m_axi_valid=0, partial lanes are not visible as a valid word; their contents are don't-care to downstream.
- RATIO=1: behaves as a forward register stage; keep is always 1 on valid words.
- s_axi_data and s_axi_last are ignored when there is no accept.

Test Plan (DATA_WIDTH=8, RATIO=4 unless stated):
- Reset, then s_axi_valid=1 for 4 cycles with data 11,22,33,44 (hex), m_axi_ready=1 -> one cycle after the 4th beat: m_axi_data=44332211, keep=F, last=0, valid for exactly 1 cycle.
- Beats AA,BB with last on BB -> m_axi_data=0000BBAA, keep=3, last=1. The next beat CC lands in lane 0 of a new word.
- Continuous 12 beats, m_axi_ready held 1 -> 3 wide words on 3 cycles, spaced exactly 4 cycles apart. s_axi_ready is never 0.
- Completed word with m_axi_ready=0 for 5 cycles -> s_axi_ready=0 and output stable throughout. On the ready=1 cycle a waiting beat DD is accepted into lane 0, and the next word is 000000DD-lane-started.
- Two beats accepted, then resetn=0 for 1 cycle, then 4 beats 01..04 -> single output 04030201, keep=F; the pre-reset beats never appear.
- RATIO=1: beats 5A,5B back-to-back with ready=1 -> output 5A then 5B on consecutive cycles, 1-cycle latency, keep=1.

Source files
------------

// File: rtl/axi_stream_packer.sv
// Width upsizer: packs RATIO narrow valid/ready beats into one registered wide beat.
// A beat flagged last closes the wide word early; unfilled lanes are zero with keep cleared.
module axi_stream_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_axi_valid,
    output logic                        s_axi_ready,
    input  logic [DATA_WIDTH-1:0]       s_axi_data,
    input  logic                        s_axi_last,
    output logic                        m_axi_valid,
    input  logic                        m_axi_ready,
    output logic [DATA_WIDTH*RATIO-1:0] m_axi_data,
    output logic [RATIO-1:0]            m_axi_keep,
    output logic                        m_axi_last
);

    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned OW = DATA_WIDTH * RATIO;

    logic [OW-1:0]    data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             xfer;
    logic             close;

    assign s_axi_ready = ~valid_q | m_axi_ready;
    assign accept      = s_axi_valid & s_axi_ready;
    assign xfer        = valid_q & m_axi_ready;
    assign close       = (cnt_q == CW'(RATIO - 1)) | s_axi_last;

    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (accept) begin
            // A new word always starts from a clean register, which also drops
            // the previous word when it leaves in this same cycle.
            if (cnt_q == '0) begin
                data_d = '0;
                keep_d = '0;
            end
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (cnt_q == CW'(i)) begin
                    data_d[i*DATA_WIDTH +: DATA_WIDTH] = s_axi_data;
                    keep_d[i]                          = 1'b1;
                end
            end
            if (close) begin
                valid_d = 1'b1;
                last_d  = s_axi_last;
                cnt_d   = '0;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                cnt_d   = cnt_q + CW'(1);
            end
        end else if (xfer) begin
            valid_d = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axi_valid = valid_q;
    assign m_axi_data  = data_q;
    assign m_axi_keep  = keep_q;
    assign m_axi_last  = last_q;

endmodule

// File: tb/tb_axi_stream_packer.sv
// Bench for axi_stream_packer: directed plan vectors plus random traffic against a
// queue-based word model, for RATIO=4 and a RATIO=1 forward-register instance.
module tb_axi_stream_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned R  = 4;

    logic          clk;
    logic          resetn;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW*R-1:0] m_data;
    logic [R-1:0]  m_keep;

    logic          r1_s_valid, r1_s_ready, r1_s_last;
    logic [DW-1:0] r1_s_data;
    logic          r1_m_valid, r1_m_ready, r1_m_last;
    logic [DW-1:0] r1_m_data;
    logic [0:0]    r1_m_keep;

    int checks = 0;
    int errors = 0;
    int words  = 0;

    // Reference state: beats collected for the word being built, and the word on offer.
    logic [DW-1:0]   cur[$];
    logic            pv;
    logic [DW*R-1:0] pdata;
    logic [R-1:0]    pkeep;
    logic            plast;
    logic            r1v;
    logic [DW-1:0]   r1d;
    logic            r1l;

    axi_stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_valid(s_valid), .s_axi_ready(s_ready), .s_axi_data(s_data), .s_axi_last(s_last),
        .m_axi_valid(m_valid), .m_axi_ready(m_ready), .m_axi_data(m_data),
        .m_axi_keep(m_keep), .m_axi_last(m_last)
    );

    axi_stream_packer #(.DATA_WIDTH(DW), .RATIO(1)) dut_r1 (
        .clk(clk), .resetn(resetn),
        .s_axi_valid(r1_s_valid), .s_axi_ready(r1_s_ready), .s_axi_data(r1_s_data), .s_axi_last(r1_s_last),
        .m_axi_valid(r1_m_valid), .m_axi_ready(r1_m_ready), .m_axi_data(r1_m_data),
        .m_axi_keep(r1_m_keep), .m_axi_last(r1_m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample and score at the falling edge, then let the rising edge commit.
    task automatic tick();
        logic            acc, xfer, rdy;
        logic [DW*R-1:0] w;
        logic [R-1:0]    k;
        @(negedge clk);
        if (!resetn) begin
            cur.delete();
            pv  = 1'b0;
            r1v = 1'b0;
        end else begin
            chk("m_valid", m_valid, pv);
            if (pv) begin
                chk("m_data", m_data, pdata);
                chk("m_keep", m_keep, pkeep);
                chk("m_last", m_last, plast);
            end
            rdy = !pv || m_ready;
            chk("s_ready", s_ready, rdy);
            if (m_valid && m_ready) words++;
            xfer = pv && m_ready;
            acc  = s_valid && rdy;
            if (xfer) pv = 1'b0;
            if (acc) begin
                cur.push_back(s_data);
                if (cur.size() == R || s_last) begin
                    w = '0;
                    k = '0;
                    foreach (cur[i]) begin
                        w[i*DW +: DW] = cur[i];
                        k[i] = 1'b1;
                    end
                    pdata = w;
                    pkeep = k;
                    plast = s_last;
                    pv    = 1'b1;
                    cur.delete();
                end
            end

            chk("r1_m_valid", r1_m_valid, r1v);
            if (r1v) begin
                chk("r1_m_data", r1_m_data, r1d);
                chk("r1_m_keep", r1_m_keep, 1'b1);
                chk("r1_m_last", r1_m_last, r1l);
            end
            rdy = !r1v || r1_m_ready;
            chk("r1_s_ready", r1_s_ready, rdy);
            if (r1v && r1_m_ready) r1v = 1'b0;
            if (r1_s_valid && rdy) begin
                r1v = 1'b1;
                r1d = r1_s_data;
                r1l = r1_s_last;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    initial begin
        logic [DW-1:0] seq[4];
        int w0;
        resetn = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        r1_s_valid = 1'b0; r1_s_data = '0; r1_s_last = 1'b0; r1_m_ready = 1'b1;
        tick();
        tick();
        resetn = 1'b1;

        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_keep", m_keep, 4'h0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);

        // RATIO=1 forward stage: 5A then 5B on consecutive cycles
        r1_s_valid = 1'b1; r1_s_data = 8'h5A; tick();
        chk("r1_first", {r1_m_valid, r1_m_data, r1_m_keep}, {1'b1, 8'h5A, 1'b1});
        r1_s_data = 8'h5B; tick();
        chk("r1_second", {r1_m_valid, r1_m_data, r1_m_keep}, {1'b1, 8'h5B, 1'b1});
        r1_s_valid = 1'b0; tick();
        chk("r1_idle", r1_m_valid, 1'b0);

        // Full word 11,22,33,44
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("fill_no_valid", m_valid, 1'b0);
            beat(seq[i], 1'b0);
        end
        chk("full_word", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h44332211, 4'hF, 1'b0});
        s_valid = 1'b0; tick();
        chk("one_cycle_valid", m_valid, 1'b0);
        chk("cleared_keep", m_keep, 4'h0);

        // Early close AA,BB(last); CC then starts a fresh word
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        chk("early_close", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h0000BBAA, 4'h3, 1'b1});
        beat(8'hCC, 1'b0);
        chk("restart_lane0", {m_valid, m_keep}, {1'b0, 4'h1});
        beat(8'hC1, 1'b0); beat(8'hC2, 1'b0); beat(8'hC3, 1'b0);
        chk("restart_word", m_data, 32'hC3C2C1CC);

        // 12 back-to-back beats: three words, no bubbles
        w0 = words;
        for (int i = 0; i < 12; i++) begin
            chk("stream_s_ready", s_ready, 1'b1);
            beat(8'($urandom), 1'b0);
        end
        s_valid = 1'b0; tick(); tick();
        chk("stream_words", words - w0, 4);

        // Stall: completed word held while m_ready=0
        m_ready = 1'b0;
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_s_ready", s_ready, 1'b0);
            chk("stall_data", m_data, 32'h04030201);
            beat(8'hDD, 1'b0);
        end
        m_ready = 1'b1;
        beat(8'hDD, 1'b0);
        chk("after_stall", {m_valid, m_data, m_keep}, {1'b0, 32'h000000DD, 4'h1});
        beat(8'hEE, 1'b1);
        chk("dd_word", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h0000EEDD, 4'h3, 1'b1});
        s_valid = 1'b0; tick();

        // Reset mid-word discards the partial beats
        beat(8'h77, 1'b0); beat(8'h88, 1'b0);
        s_valid = 1'b0; resetn = 1'b0; tick();
        resetn = 1'b1;
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        chk("post_reset_word", {m_valid, m_data, m_keep}, {1'b1, 32'h04030201, 4'hF});
        s_valid = 1'b0; tick();

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            s_valid    = ($urandom_range(0, 3) != 0);
            s_data     = 8'($urandom);
            s_last     = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 9) < 7);
            r1_s_valid = $urandom_range(0, 1) == 1;
            r1_s_data  = 8'($urandom);
            r1_s_last  = $urandom_range(0, 1) == 1;
            r1_m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_valid = 1'b0; r1_s_valid = 1'b0; m_ready = 1'b1; r1_m_ready = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
